// File: rtl/paddle_game_ctrl.sv
// Paddle game sequencer: key sync/debounce, IDLE/SERVE/PLAY/PAUSE/OVER FSM, move strobes and lives.
// Define PADDLE_PAUSE_EN to build the KEY[3] pause path and the PAUSE state.
module paddle_game_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int START_LIVES     = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] KEY,
   input  logic       frame_tick,
   input  logic       ball_lost,
   output logic       move_left,
   output logic       move_right,
   output logic       paddle_recenter,
   output logic       ball_launch,
   output logic [2:0] state,
   output logic [3:0] lives,
   output logic       game_over
);

`ifdef PADDLE_PAUSE_EN
   localparam int NK = 4;
`else
   localparam int NK = 3;
   logic unused_key3;
   assign unused_key3 = KEY[3];
`endif

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_PAUSE = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   logic [NK-1:0]         sync1_q, sync2_q, deb_q;
   logic [NK-1:0][CW-1:0] cnt_q;

   state_t     state_q, state_d;
   logic [3:0] lives_q, lives_d;
   logic       recenter_q, recenter_d;
   logic       launch_q, launch_d;
   logic       mleft_q, mright_q;
   logic       press2, in_move;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= '1;
         sync2_q <= '1;
         deb_q   <= '1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= KEY[NK-1:0];
         sync2_q <= sync1_q;
         for (int k = 0; k < NK; k++) begin
            if (sync2_q[k] == deb_q[k]) begin
               cnt_q[k] <= '0;
            end else if (cnt_q[k] == CNT_MAX) begin
               deb_q[k] <= sync2_q[k];
               cnt_q[k] <= '0;
            end else begin
               cnt_q[k] <= cnt_q[k] + 1'b1;
            end
         end
      end
   end

   // Press fires in the cycle the debounced level is about to fall, so the FSM acts on the same edge.
   assign press2 = deb_q[2] & ~sync2_q[2] & (cnt_q[2] == CNT_MAX);
`ifdef PADDLE_PAUSE_EN
   logic press3;
   assign press3 = deb_q[3] & ~sync2_q[3] & (cnt_q[3] == CNT_MAX);
`endif

   always_comb begin
      state_d    = state_q;
      lives_d    = lives_q;
      recenter_d = 1'b0;
      launch_d   = 1'b0;
      case (state_q)
         S_IDLE: if (press2) begin
            state_d    = S_SERVE;
            recenter_d = 1'b1;
         end
         S_SERVE: if (press2) begin
            state_d  = S_PLAY;
            launch_d = 1'b1;
         end
         S_PLAY: begin
            if (ball_lost) begin
               if (lives_q > 4'd1) begin
                  lives_d    = lives_q - 4'd1;
                  state_d    = S_SERVE;
                  recenter_d = 1'b1;
               end else begin
                  lives_d = 4'd0;
                  state_d = S_OVER;
               end
            end
`ifdef PADDLE_PAUSE_EN
            else if (press3) state_d = S_PAUSE;
`endif
         end
`ifdef PADDLE_PAUSE_EN
         S_PAUSE: if (press3) state_d = S_PLAY;
`endif
         S_OVER: if (press2) begin
            state_d = S_IDLE;
            lives_d = 4'(START_LIVES);
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign in_move = (state_q == S_SERVE) || (state_q == S_PLAY);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         lives_q    <= 4'(START_LIVES);
         recenter_q <= 1'b0;
         launch_q   <= 1'b0;
         mleft_q    <= 1'b0;
         mright_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         lives_q    <= lives_d;
         recenter_q <= recenter_d;
         launch_q   <= launch_d;
         mleft_q    <= frame_tick & in_move & ~deb_q[0];
         mright_q   <= frame_tick & in_move & deb_q[0] & ~deb_q[1];
      end
   end

   assign move_left       = mleft_q;
   assign move_right      = mright_q;
   assign paddle_recenter = recenter_q;
   assign ball_launch     = launch_q;
   assign state           = state_q;
   assign lives           = lives_q;
   assign game_over       = (state_q == S_OVER);

endmodule

// File: tb/tb_paddle_game_ctrl.sv
// Scoreboard bench for paddle_game_ctrl: stimulus queues expected output events with their cycle,
// a negedge monitor pops and compares every pulse or state/lives change the DUT shows.
module tb_paddle_game_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] KEY = 4'hF;
   logic       frame_tick = 1'b0;
   logic       ball_lost  = 1'b0;
   logic       move_left, move_right, paddle_recenter, ball_launch, game_over;
   logic [2:0] state;
   logic [3:0] lives;

   paddle_game_ctrl #(.DEBOUNCE_CYCLES(4), .START_LIVES(3)) dut (
      .clk(clk), .rst(rst), .KEY(KEY), .frame_tick(frame_tick), .ball_lost(ball_lost),
      .move_left(move_left), .move_right(move_right), .paddle_recenter(paddle_recenter),
      .ball_launch(ball_launch), .state(state), .lives(lives), .game_over(game_over)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   typedef struct {
      int         cyc;
      logic [2:0] st;
      logic [3:0] lv;
      logic       ml, mr, rc, bl, go;
   } ev_t;

   ev_t exp_q[$];
   int  tests = 0;
   int  fails = 0;
   logic [2:0] prev_st = 3'b111;
   logic [3:0] prev_lv = 4'hF;

   task automatic push(input logic [2:0] st, input logic [3:0] lv,
                       input logic ml, input logic mr, input logic rc, input logic bl, input int dc);
      ev_t e;
      e.cyc = cyc + dc; e.st = st; e.lv = lv;
      e.ml = ml; e.mr = mr; e.rc = rc; e.bl = bl; e.go = (st == 3'd4);
      exp_q.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Key low long enough to debounce, then released and re-debounced.
   task automatic press(input int i);
      KEY[i] = 1'b0; step(8);
      KEY[i] = 1'b1; step(8);
   endtask

   task automatic tick();
      frame_tick = 1'b1; step(1); frame_tick = 1'b0; step(3);
   endtask

   task automatic lose();
      ball_lost = 1'b1; step(1); ball_lost = 1'b0; step(3);
   endtask

   always @(negedge clk) begin
      if (state !== prev_st || lives !== prev_lv ||
          (move_left | move_right | paddle_recenter | ball_launch) === 1'b1) begin
         ev_t e;
         prev_st = state;
         prev_lv = lives;
         tests = tests + 1;
         if (exp_q.size() == 0) begin
            fails = fails + 1;
            $display("FAIL unexpected_event cyc=%0d got st=%0d lv=%0d ml=%b mr=%b rc=%b bl=%b go=%b, required none",
                     cyc, state, lives, move_left, move_right, paddle_recenter, ball_launch, game_over);
         end else begin
            e = exp_q.pop_front();
            if (cyc != e.cyc || state !== e.st || lives !== e.lv || move_left !== e.ml ||
                move_right !== e.mr || paddle_recenter !== e.rc || ball_launch !== e.bl ||
                game_over !== e.go)
            begin
               fails = fails + 1;
               $display("FAIL event got cyc=%0d st=%0d lv=%0d ml=%b mr=%b rc=%b bl=%b go=%b required cyc=%0d st=%0d lv=%0d ml=%b mr=%b rc=%b bl=%b go=%b",
                        cyc, state, lives, move_left, move_right, paddle_recenter, ball_launch, game_over,
                        e.cyc, e.st, e.lv, e.ml, e.mr, e.rc, e.bl, e.go);
            end
         end
      end
   end

   initial begin
      // Reset state shows after the first edge.
      push(3'd0, 4'd3, 0, 0, 0, 0, 1);
      step(2);
      rst = 1'b1;
      step(1);

      // Held key and frame_tick in IDLE: no strobe.
      KEY[1] = 1'b0; step(8); tick(); KEY[1] = 1'b1; step(8);

      // Start: SERVE + recenter 6 clocks after the key edge.
      push(3'd1, 4'd3, 0, 0, 1, 0, 6);
      press(2);

      // Both direction keys held: left wins, one clock after each tick.
      KEY[0] = 1'b0; KEY[1] = 1'b0; step(8);
      for (int i = 0; i < 3; i++) begin
         push(3'd1, 4'd3, 1, 0, 0, 0, 1);
         tick();
      end
      KEY[0] = 1'b1; KEY[1] = 1'b1; step(8);

      // Two-clock glitch on KEY[0] never debounces.
      KEY[0] = 1'b0; step(1); frame_tick = 1'b1; step(1); frame_tick = 1'b0; KEY[0] = 1'b1;
      step(3); tick(); step(8); tick();

      // Lose all three lives, relaunching in between.
      push(3'd2, 4'd3, 0, 0, 0, 1, 6); press(2);
      push(3'd1, 4'd2, 0, 0, 1, 0, 1); lose();
      push(3'd2, 4'd2, 0, 0, 0, 1, 6); press(2);
      push(3'd1, 4'd1, 0, 0, 1, 0, 1); lose();
      push(3'd2, 4'd1, 0, 0, 0, 1, 6); press(2);
      push(3'd4, 4'd0, 0, 0, 0, 0, 1); lose();
      lose();
      push(3'd0, 4'd3, 0, 0, 0, 0, 6); press(2);

      // Back to PLAY, then ball_lost coinciding with a start press.
      push(3'd1, 4'd3, 0, 0, 1, 0, 6); press(2);
      push(3'd2, 4'd3, 0, 0, 0, 1, 6); press(2);
      push(3'd1, 4'd2, 0, 0, 1, 0, 6);
      KEY[2] = 1'b0; step(5);
      ball_lost = 1'b1; step(1); ball_lost = 1'b0; step(2);
      KEY[2] = 1'b1; step(8);
      push(3'd2, 4'd2, 0, 0, 0, 1, 6); press(2);

`ifdef PADDLE_PAUSE_EN
      push(3'd3, 4'd2, 0, 0, 0, 0, 6); press(3);
      KEY[1] = 1'b0; step(8);
      tick(); lose(); press(2);
      KEY[1] = 1'b1; step(8);
      push(3'd2, 4'd2, 0, 0, 0, 0, 6); press(3);
`else
      press(3);
`endif

      // Right strobe in PLAY.
      KEY[1] = 1'b0; step(8);
      push(3'd2, 4'd2, 0, 1, 0, 0, 1); tick();
      KEY[1] = 1'b1; step(8);

      // Reset mid-PLAY returns to IDLE with lives reloaded on the next clock.
      push(3'd0, 4'd3, 0, 0, 0, 0, 1);
      rst = 1'b0; step(2); rst = 1'b1; step(10);

      tests = tests + 1;
      if (exp_q.size() != 0) begin
         fails = fails + 1;
         $display("FAIL missing_events got %0d pending, required 0 (next cyc=%0d st=%0d)",
                  exp_q.size(), exp_q[0].cyc, exp_q[0].st);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
